game_round_controller: RTL and testbench
========================================

# game_round_controller

Clocked round sequencer for the binary number game. It owns the game state machine: arming the number generator, loading the countdown timer with a per-level time budget, judging a guess against the comparator result, and tracking level, score and lives. It sits between the button/comparator/timer/generator blocks and the display, replacing the purely combinational game logic with a registered controller.

## Interface
Parameters:
- START_TIME, 20, timer budget (seconds) at level 0; 5 bits
- MIN_TIME, 5, floor of the timer budget; 5 bits
- TIME_STEP, 1, budget reduction per level
- LIVES, 3, lives at game start; 1..3
- HOLD_CYCLES, 50_000_000, cycles the WIN/MISS result state is held for display

Ports:
- clk  in  1  system clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- start_b  in  1  debounced start pulse, one cycle wide
- guess_b  in  1  debounced guess pulse, one cycle wide
- cmp_r  in  1  comparator match: switches equal the generated number
- end_f  in  1  timer expired, level-sensitive
- state  out  3  current FSM state code
- level  out  8  current level
- score  out  8  correct guesses this game
- lives  out  2  lives remaining
- g_enable  out  1  one-cycle pulse requesting a new number from the generator
- time_f  out  1  one-cycle timer load strobe
- time_v  out  5  timer load value, valid while time_f is high

## Operation
State codes:
- IDLE = 0
- ARM = 1
- LOAD = 2
- PLAY = 3
- WIN = 4
- MISS = 5
- OVER = 6

Transitions:
- IDLE: on start_b, set level=0, score=0, lives=LIVES, then go to ARM.
- ARM: g_enable=1 for exactly this cycle; go to LOAD unconditionally.
- LOAD: time_f=1; time_v = max(MIN_TIME, START_TIME − level·TIME_STEP). The subtraction is computed at ≥13-bit width and clamps at MIN_TIME, so it never wraps. Go to PLAY.
- PLAY:
  - guess_b with cmp_r=1: go to WIN.
  - guess_b with cmp_r=0: go to MISS.
  - end_f with no guess_b: go to MISS.
  - guess_b and end_f in the same cycle: the guess takes priority and is judged by cmp_r.
  - Otherwise stay.
- WIN: on entry, level = level+1 and score = score+1, each saturating at 255. Hold for HOLD_CYCLES, then go to ARM.
- MISS: on entry, lives = lives−1. If the new lives is 0, go to OVER on the next cycle. Otherwise hold HOLD_CYCLES, then go to ARM at the same level.
- OVER: level and score are frozen for display. On start_b, reinitialise as in IDLE and go to ARM.

Ignored inputs:
- guess_b outside PLAY is ignored.
- start_b outside IDLE/OVER is ignored.
- end_f outside PLAY is ignored. The stale expiry flag from a previous round cannot cause a MISS, because the LOAD strobe precedes PLAY.

General:
- The hold counter is ⌈log2(HOLD_CYCLES+1)⌉ bits. It is cleared on entry to WIN/MISS and compared against HOLD_CYCLES−1.
- All outputs are registered; there is no combinational path from any input to any output.

## Timing
Reset values:
- rst high on any edge forces state=IDLE, level=0, score=0, lives=0, g_enable=0, time_f=0, time_v=0, and clears the hold counter.
- Reset mid-round abandons the round with no further strobes.

Cycle timing:
- start_b sampled in IDLE at edge N: state=ARM and g_enable=1 after edge N+1. After edge N+2: state=LOAD, time_f=1, g_enable=0. After edge N+3: state=PLAY, time_f=0.
- guess_b sampled in PLAY at edge M: WIN/MISS is visible after M+1, together with the updated level/score/lives.
- WIN/MISS → ARM occurs HOLD_CYCLES cycles after entry.
- MISS with the last life lost: OVER is visible one cycle after MISS. No hold is applied.

Handshake rules:
- g_enable and time_f are never high in the same cycle.
- Each is high for exactly one cycle per round.
- time_v holds its value between loads.

## Test plan
- Reset, then start_b → g_enable is a single pulse, then time_f pulse with time_v=20 one cycle later; lives=3, level=0; state goes 1→2→3.
- PLAY, guess_b with cmp_r=1 → WIN; level=1, score=1. After HOLD_CYCLES, a new ARM/LOAD with time_v=19.
- PLAY, end_f=1 with no guess → MISS, lives=2. Re-arm at the same level with time_v unchanged.
- Three consecutive misses → lives=0, state=OVER one cycle after the third MISS. guess_b then ignored; start_b restarts with lives=3, score=0.
- Level forced to 30 (repeated wins) → time_v clamps at 5; level/score saturate at 255 with no wrap.
- guess_b and end_f in the same PLAY cycle with cmp_r=1 → WIN, not MISS. rst asserted in PLAY → next cycle all outputs are at their reset values and state=IDLE.

Source files
------------

// File: rtl/game_round_controller_if.sv
// Signal bundle between the round controller and its button, comparator,
// timer, generator and display neighbours.
interface game_round_controller_if;
  logic       start_b;
  logic       guess_b;
  logic       cmp_r;
  logic       end_f;
  logic [2:0] state;
  logic [7:0] level;
  logic [7:0] score;
  logic [1:0] lives;
  logic       g_enable;
  logic       time_f;
  logic [4:0] time_v;

  modport master (
    output start_b, guess_b, cmp_r, end_f,
    input  state, level, score, lives, g_enable, time_f, time_v
  );

  modport slave (
    input  start_b, guess_b, cmp_r, end_f,
    output state, level, score, lives, g_enable, time_f, time_v
  );
endinterface

// File: rtl/game_round_controller.sv
// Registered round sequencer for the binary number game: arms the generator,
// loads the per-level timer budget, judges guesses, tracks level/score/lives.
//
// state | meaning
// IDLE  | waiting for start_b after reset
// ARM   | g_enable pulse, new number requested
// LOAD  | time_f pulse, timer loaded with level budget
// PLAY  | waiting for guess or timer expiry
// WIN   | correct guess, result held for display
// MISS  | wrong guess or timeout, result held unless out of lives
// OVER  | no lives left, level/score frozen until start_b
module game_round_controller #(
  parameter int START_TIME  = 20,
  parameter int MIN_TIME    = 5,
  parameter int TIME_STEP   = 1,
  parameter int LIVES       = 3,
  parameter int HOLD_CYCLES = 50_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  game_round_controller_if.slave bus
);

  localparam int HOLD_W = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARM  = 3'd1,
    S_LOAD = 3'd2,
    S_PLAY = 3'd3,
    S_WIN  = 3'd4,
    S_MISS = 3'd5,
    S_OVER = 3'd6
  } state_t;

  state_t            st;
  logic [HOLD_W-1:0] hold_cnt;
  logic [7:0]        level_r;
  logic [7:0]        score_r;
  logic [1:0]        lives_r;
  logic              g_enable_r;
  logic              time_f_r;
  logic [4:0]        time_v_r;

  // Budget worked at 16 bits so a large level cannot wrap below the floor.
  logic [15:0] time_dec;
  logic [15:0] time_diff;
  logic [4:0]  budget;

  assign time_dec  = 16'(level_r) * 16'(TIME_STEP);
  assign time_diff = 16'(START_TIME) - time_dec;

  always_comb begin
    budget = 5'(MIN_TIME);
    if ((time_dec < 16'(START_TIME)) && (time_diff > 16'(MIN_TIME)))
      budget = 5'(time_diff);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st         <= S_IDLE;
      hold_cnt   <= '0;
      level_r    <= '0;
      score_r    <= '0;
      lives_r    <= '0;
      g_enable_r <= 1'b0;
      time_f_r   <= 1'b0;
      time_v_r   <= '0;
    end else begin
      g_enable_r <= 1'b0;
      time_f_r   <= 1'b0;
      case (st)
        S_IDLE, S_OVER: begin
          if (bus.start_b) begin
            level_r    <= '0;
            score_r    <= '0;
            lives_r    <= 2'(LIVES);
            g_enable_r <= 1'b1;
            st         <= S_ARM;
          end
        end
        S_ARM: begin
          time_f_r <= 1'b1;
          time_v_r <= budget;
          st       <= S_LOAD;
        end
        S_LOAD: st <= S_PLAY;
        S_PLAY: begin
          hold_cnt <= '0;
          if (bus.guess_b && bus.cmp_r) begin
            if (level_r != 8'hFF) level_r <= level_r + 8'd1;
            if (score_r != 8'hFF) score_r <= score_r + 8'd1;
            st <= S_WIN;
          end else if (bus.guess_b || bus.end_f) begin
            if (lives_r != 2'd0) lives_r <= lives_r - 2'd1;
            st <= S_MISS;
          end
        end
        S_WIN, S_MISS: begin
          if ((st == S_MISS) && (lives_r == 2'd0)) begin
            st <= S_OVER;
          end else if (hold_cnt == HOLD_LAST) begin
            g_enable_r <= 1'b1;
            st         <= S_ARM;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: st <= S_IDLE;
      endcase
    end
  end

  assign bus.state    = st;
  assign bus.level    = level_r;
  assign bus.score    = score_r;
  assign bus.lives    = lives_r;
  assign bus.g_enable = g_enable_r;
  assign bus.time_f   = time_f_r;
  assign bus.time_v   = time_v_r;

endmodule

// File: tb/tb_game_round_controller.sv
// Directed bench for game_round_controller with a short hold time.
module tb_game_round_controller;
  localparam int HOLD = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;

  game_round_controller_if bus ();

  game_round_controller #(
    .START_TIME(20), .MIN_TIME(5), .TIME_STEP(1), .LIVES(3), .HOLD_CYCLES(HOLD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_state"}, 16'(bus.state), 16'd0);
    check({tag, "_level"}, 16'(bus.level), 16'd0);
    check({tag, "_score"}, 16'(bus.score), 16'd0);
    check({tag, "_lives"}, 16'(bus.lives), 16'd0);
    check({tag, "_genable"}, 16'(bus.g_enable), 16'd0);
    check({tag, "_timef"}, 16'(bus.time_f), 16'd0);
    check({tag, "_timev"}, 16'(bus.time_v), 16'd0);
  endtask

  initial begin
    int lvl;
    int exp_tv;
    bus.start_b = 1'b0;
    bus.guess_b = 1'b0;
    bus.cmp_r   = 1'b0;
    bus.end_f   = 1'b0;
    tick();
    tick();
    check_reset("reset");
    rst = 1'b0;
    tick();

    // start: ARM -> LOAD -> PLAY
    bus.start_b = 1'b1; tick(); bus.start_b = 1'b0;
    check("arm_state", 16'(bus.state), 16'd1);
    check("arm_genable", 16'(bus.g_enable), 16'd1);
    check("arm_timef", 16'(bus.time_f), 16'd0);
    check("arm_lives", 16'(bus.lives), 16'd3);
    check("arm_level", 16'(bus.level), 16'd0);
    tick();
    check("load_state", 16'(bus.state), 16'd2);
    check("load_timef", 16'(bus.time_f), 16'd1);
    check("load_genable", 16'(bus.g_enable), 16'd0);
    check("load_timev", 16'(bus.time_v), 16'd20);
    tick();
    check("play_state", 16'(bus.state), 16'd3);
    check("play_timef", 16'(bus.time_f), 16'd0);
    check("play_timev_held", 16'(bus.time_v), 16'd20);
    bus.start_b = 1'b1; tick(); bus.start_b = 1'b0;
    check("play_start_ignored", 16'(bus.state), 16'd3);

    // correct guess -> WIN, hold, re-arm with budget 19
    bus.guess_b = 1'b1; bus.cmp_r = 1'b1; tick();
    bus.guess_b = 1'b0; bus.cmp_r = 1'b0;
    check("win_state", 16'(bus.state), 16'd4);
    check("win_level", 16'(bus.level), 16'd1);
    check("win_score", 16'(bus.score), 16'd1);
    repeat (HOLD - 1) tick();
    check("win_hold_state", 16'(bus.state), 16'd4);
    tick();
    check("win_rearm_state", 16'(bus.state), 16'd1);
    check("win_rearm_genable", 16'(bus.g_enable), 16'd1);
    tick();
    check("win_load_timev", 16'(bus.time_v), 16'd19);
    check("win_load_timef", 16'(bus.time_f), 16'd1);
    tick();

    // timeout -> MISS, re-arm at same level
    bus.end_f = 1'b1; tick(); bus.end_f = 1'b0;
    check("timeout_state", 16'(bus.state), 16'd5);
    check("timeout_lives", 16'(bus.lives), 16'd2);
    check("timeout_level", 16'(bus.level), 16'd1);
    repeat (HOLD - 1) tick();
    check("miss_hold_state", 16'(bus.state), 16'd5);
    tick();
    check("miss_rearm_state", 16'(bus.state), 16'd1);
    tick();
    check("miss_load_timev", 16'(bus.time_v), 16'd19);
    tick();

    // wrong guess -> MISS
    bus.guess_b = 1'b1; bus.cmp_r = 1'b0; tick(); bus.guess_b = 1'b0;
    check("wrong_state", 16'(bus.state), 16'd5);
    check("wrong_lives", 16'(bus.lives), 16'd1);
    check("wrong_score", 16'(bus.score), 16'd1);
    repeat (HOLD) tick();
    tick();
    tick();
    check("third_play_state", 16'(bus.state), 16'd3);

    // last life lost -> OVER one cycle later, no hold
    bus.end_f = 1'b1; tick(); bus.end_f = 1'b0;
    check("last_miss_state", 16'(bus.state), 16'd5);
    check("last_miss_lives", 16'(bus.lives), 16'd0);
    tick();
    check("over_state", 16'(bus.state), 16'd6);
    check("over_level", 16'(bus.level), 16'd1);
    check("over_score", 16'(bus.score), 16'd1);
    bus.guess_b = 1'b1; bus.cmp_r = 1'b1; tick();
    bus.guess_b = 1'b0; bus.cmp_r = 1'b0;
    check("over_guess_ignored", 16'(bus.state), 16'd6);
    check("over_genable", 16'(bus.g_enable), 16'd0);

    // restart from OVER
    bus.start_b = 1'b1; tick(); bus.start_b = 1'b0;
    check("restart_state", 16'(bus.state), 16'd1);
    check("restart_lives", 16'(bus.lives), 16'd3);
    check("restart_score", 16'(bus.score), 16'd0);
    check("restart_level", 16'(bus.level), 16'd0);
    tick();
    check("restart_timev", 16'(bus.time_v), 16'd20);
    tick();

    // guess and expiry together: guess wins
    bus.guess_b = 1'b1; bus.end_f = 1'b1; bus.cmp_r = 1'b1; tick();
    bus.guess_b = 1'b0; bus.end_f = 1'b0; bus.cmp_r = 1'b0;
    check("both_state", 16'(bus.state), 16'd4);
    check("both_lives", 16'(bus.lives), 16'd3);
    check("both_level", 16'(bus.level), 16'd1);

    // repeated wins: budget floor at 5, level/score saturate at 255
    for (int i = 2; i <= 256; i++) begin
      lvl = i - 1;
      exp_tv = (lvl >= 15) ? 5 : 20 - lvl;
      repeat (HOLD) tick();
      check("loop_arm_state", 16'(bus.state), 16'd1);
      tick();
      check("loop_timev", 16'(bus.time_v), 16'(exp_tv));
      tick();
      bus.guess_b = 1'b1; bus.cmp_r = 1'b1; tick();
      bus.guess_b = 1'b0; bus.cmp_r = 1'b0;
      check("loop_level", 16'(bus.level), 16'((i > 255) ? 255 : i));
      check("loop_score", 16'(bus.score), 16'((i > 255) ? 255 : i));
    end

    // reset in the middle of a round
    repeat (HOLD) tick();
    tick();
    tick();
    check("pre_reset_play", 16'(bus.state), 16'd3);
    rst = 1'b1; tick();
    check_reset("midround_reset");
    rst = 1'b0; tick();
    check("post_reset_idle", 16'(bus.state), 16'd0);
    check("post_reset_genable", 16'(bus.g_enable), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
